echo_request_input: RTL and testbench

ECHO_REQUEST_INPUT -- requirements
Module: echo_request_input

---
 rtl/echo_req_pkg.sv | 27 ++
 rtl/req_fifo2.sv | 65 ++++++
 rtl/echo_request_input.sv | 148 ++++++++++++++
 tb/tb_echo_request_input.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_req_pkg.sv
// Shared definitions for the echo request input path: header field
// positions, the say() method number and payload size, and FSM encoding.
package echo_req_pkg;

    localparam int HDR_METHOD_MSB = 31;
    localparam int HDR_METHOD_LSB = 16;
    localparam int HDR_LEN_MSB    = 15;
    localparam int HDR_LEN_LSB    = 0;

    localparam logic [15:0] METHOD_SAY    = 16'd0;
    localparam logic [15:0] SAY_SIZE_BITS = 16'd32;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_PAY  = 2'd1,
        ST_DROP = 2'd2
    } req_state_t;

    function automatic logic [15:0] hdr_method(input logic [31:0] word);
        return word[HDR_METHOD_MSB:HDR_METHOD_LSB];
    endfunction

    function automatic logic [15:0] hdr_len(input logic [31:0] word);
        return word[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

endpackage

// File: rtl/req_fifo2.sv
// Two-entry, 32-bit registered FIFO used as the say() output buffer.
// Head is always r_data0; a push and pop together on one entry keeps
// occupancy at one. Enqueue is refused while full, even if a pop is
// happening in the same cycle.
module req_fifo2 (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] enq_v,
    input  logic        EN_enq,
    output logic        RDY_enq,
    input  logic        EN_deq,
    output logic        RDY_deq,
    output logic [31:0] first,
    output logic        RDY_first
);

    logic [1:0]  r_count;
    logic [31:0] r_data0;
    logic [31:0] r_data1;
    logic        w_do_enq;
    logic        w_do_deq;

    assign RDY_enq   = (r_count != 2'd2);
    assign RDY_deq   = (r_count != 2'd0);
    assign RDY_first = (r_count != 2'd0);
    assign first     = r_data0;
    assign w_do_enq  = EN_enq & RDY_enq;
    assign w_do_deq  = EN_deq & RDY_deq;

    // Storage and occupancy update for push, pop, or both.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_count <= 2'd0;
            r_data0 <= 32'd0;
            r_data1 <= 32'd0;
        end else begin
            case ({w_do_enq, w_do_deq})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_data0 <= enq_v;
                    end else begin
                        r_data1 <= enq_v;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_data0 <= enq_v;
                    end else begin
                        r_data0 <= r_data1;
                        r_data1 <= enq_v;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

endmodule

// File: rtl/echo_request_input.sv
// Echo request input: parses the portal word stream into messages and
// turns method-0 (say) payloads into EN_say/say_v calls through a 2-entry
// buffer. Unknown, oversize or malformed messages are skipped.
// Optional feature: define ECHO_REQ_ERRCNT_EN to add the saturating
// err_count output counting erroneous headers.
module echo_request_input
    import echo_req_pkg::*;
#(
    parameter int MAX_LEN = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] portalIfc_requests_0_enq_v,
    input  logic        EN_portalIfc_requests_0_enq,
    output logic        RDY_portalIfc_requests_0_enq,
    input  logic [15:0] portalIfc_messageSize_size_methodNumber,
    output logic [15:0] portalIfc_messageSize_size,
    output logic        RDY_portalIfc_messageSize_size,
    output logic [31:0] say_v,
    output logic        EN_say,
    input  logic        RDY_say
`ifdef ECHO_REQ_ERRCNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    req_state_t  r_state;
    logic [15:0] r_drop_cnt;

    logic        w_rdy_enq;
    logic        w_enq_fire;
    logic [15:0] w_method;
    logic [15:0] w_len;
    logic        w_is_say;
    logic        w_fifo_enq;
    logic        w_fifo_rdy_enq;
    logic        w_fifo_rdy_deq;
    logic        w_fifo_rdy_first;
    logic [31:0] w_fifo_first;

    assign w_method   = hdr_method(portalIfc_requests_0_enq_v);
    assign w_len      = hdr_len(portalIfc_requests_0_enq_v);
    assign w_is_say   = (w_method == METHOD_SAY) && (w_len == 16'd1) && (w_len <= MAX_LEN_W);
    assign w_enq_fire = EN_portalIfc_requests_0_enq & w_rdy_enq;
    assign w_fifo_enq = w_enq_fire & (r_state == ST_PAY);

    // Input ready: only a say payload can be held off, and only by a full buffer.
    always_comb begin
        w_rdy_enq = 1'b1;
        case (r_state)
            ST_PAY:  w_rdy_enq = w_fifo_rdy_enq;
            ST_HDR:  w_rdy_enq = 1'b1;
            ST_DROP: w_rdy_enq = 1'b1;
            default: w_rdy_enq = 1'b1;
        endcase
    end

    assign RDY_portalIfc_requests_0_enq = w_rdy_enq;

    // Method size query is pure decode so it keeps working through reset.
    always_comb begin
        if (portalIfc_messageSize_size_methodNumber == METHOD_SAY) begin
            portalIfc_messageSize_size = SAY_SIZE_BITS;
        end else begin
            portalIfc_messageSize_size = 16'd0;
        end
    end

    assign RDY_portalIfc_messageSize_size = 1'b1;

    // Message framing FSM: header decode, say payload capture, discard count.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_HDR;
            r_drop_cnt <= 16'd0;
        end else if (w_enq_fire) begin
            case (r_state)
                ST_HDR: begin
                    if (w_len == 16'd0) begin
                        r_state <= ST_HDR;
                    end else if (w_is_say) begin
                        r_state <= ST_PAY;
                    end else begin
                        r_state    <= ST_DROP;
                        r_drop_cnt <= w_len;
                    end
                end
                ST_PAY: begin
                    r_state <= ST_HDR;
                end
                ST_DROP: begin
                    r_drop_cnt <= r_drop_cnt - 16'd1;
                    if (r_drop_cnt == 16'd1) begin
                        r_state <= ST_HDR;
                    end else begin
                        r_state <= ST_DROP;
                    end
                end
                default: begin
                    r_state    <= ST_HDR;
                    r_drop_cnt <= 16'd0;
                end
            endcase
        end else begin
            r_state <= r_state;
        end
    end

`ifdef ECHO_REQ_ERRCNT_EN
    logic        w_hdr_err;
    logic [15:0] r_err_count;

    // Any accepted header that is not a well-formed say call is an error.
    assign w_hdr_err = w_enq_fire & (r_state == ST_HDR) & ~w_is_say;

    // Saturating count of erroneous headers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_err_count <= 16'd0;
        end else if (w_hdr_err && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end else begin
            r_err_count <= r_err_count;
        end
    end

    assign err_count = r_err_count;
`endif

    req_fifo2 u_out_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .enq_v     (portalIfc_requests_0_enq_v),
        .EN_enq    (w_fifo_enq),
        .RDY_enq   (w_fifo_rdy_enq),
        .EN_deq    (EN_say),
        .RDY_deq   (w_fifo_rdy_deq),
        .first     (w_fifo_first),
        .RDY_first (w_fifo_rdy_first)
    );

    assign EN_say = w_fifo_rdy_first & w_fifo_rdy_deq & RDY_say;
    assign say_v  = w_fifo_first;

endmodule

// File: tb/tb_echo_request_input.sv
// Scoreboard bench for echo_request_input: stimulus pushes expected say()
// arguments into a queue, a monitor pops and compares on every EN_say.
module tb_echo_request_input;

    logic        CLK;
    logic        RST_N;
    logic [31:0] enq_v;
    logic        en_enq;
    logic        rdy_enq;
    logic [15:0] ms_method;
    logic [15:0] ms_size;
    logic        ms_rdy;
    logic [31:0] say_v;
    logic        en_say;
    logic        rdy_say;
`ifdef ECHO_REQ_ERRCNT_EN
    logic [15:0] err_count;
    int          exp_err;
`endif

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    echo_request_input #(.MAX_LEN(8)) dut (
        .CLK                                    (CLK),
        .RST_N                                  (RST_N),
        .portalIfc_requests_0_enq_v             (enq_v),
        .EN_portalIfc_requests_0_enq            (en_enq),
        .RDY_portalIfc_requests_0_enq           (rdy_enq),
        .portalIfc_messageSize_size_methodNumber(ms_method),
        .portalIfc_messageSize_size             (ms_size),
        .RDY_portalIfc_messageSize_size         (ms_rdy),
        .say_v                                  (say_v),
        .EN_say                                 (en_say),
        .RDY_say                                (rdy_say)
`ifdef ECHO_REQ_ERRCNT_EN
        ,
        .err_count                              (err_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_err(input string name);
`ifdef ECHO_REQ_ERRCNT_EN
        check(name, {16'd0, err_count}, exp_err);
`endif
    endtask

    task automatic note_err();
`ifdef ECHO_REQ_ERRCNT_EN
        exp_err++;
`endif
    endtask

    task automatic clr_err();
`ifdef ECHO_REQ_ERRCNT_EN
        exp_err = 0;
`endif
    endtask

    // Monitor: every EN_say must match the oldest expected say() argument.
    always @(negedge CLK) begin
        if (RST_N && en_say) begin
            if (exp_q.size() == 0) begin
                check("unexpected_say", say_v, 32'hxxxxxxxx);
            end else begin
                check("say_v", say_v, exp_q.pop_front());
            end
        end
    end

    // Transfer one word, waiting (bounded) for RDY.
    task automatic send(input logic [31:0] w);
        int t;
        t = 0;
        @(negedge CLK);
        enq_v  = w;
        en_enq = 1'b1;
        while (!rdy_enq && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 200) check("send_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1 en_enq = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge CLK);
            t++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("rst_rdy_enq", {31'd0, rdy_enq}, 32'd1);
        check("rst_en_say", {31'd0, en_say}, 32'd0);
        ms_method = 16'd0;
        #1 check("rst_msize_0", {16'd0, ms_size}, 32'd32);
        @(negedge CLK);
        RST_N = 1'b1;
        clr_err();
        #1;
        check("post_rst_rdy_enq", {31'd0, rdy_enq}, 32'd1);
        check("post_rst_en_say", {31'd0, en_say}, 32'd0);
        chk_err("post_rst_err");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_N     = 1'b0;
        enq_v     = 32'd0;
        en_enq    = 1'b0;
        rdy_say   = 1'b1;
        ms_method = 16'd7;
        clr_err();
        #1;
        check("rst_msize_7", {16'd0, ms_size}, 32'd0);
        check("msize_rdy", {31'd0, ms_rdy}, 32'd1);
        repeat (3) @(posedge CLK);
        do_reset();

        // Basic say call with one-cycle delivery latency.
        send(32'h00000001);
        @(negedge CLK);
        enq_v  = 32'hDEADBEEF;
        en_enq = 1'b1;
        check("pay_rdy", {31'd0, rdy_enq}, 32'd1);
        check("pay_no_say_yet", {31'd0, en_say}, 32'd0);
        exp_q.push_back(32'hDEADBEEF);
        @(posedge CLK);
        #1 en_enq = 1'b0;
        check("say_next_cycle", {31'd0, en_say}, 32'd1);
        drain();

        // Unknown method 5, length 3: all words dropped, then a good call.
        send(32'h00050003);
        note_err();
        send(32'h11111111);
        check("drop_rdy", {31'd0, rdy_enq}, 32'd1);
        send(32'h22222222);
        send(32'h33333333);
        chk_err("err_after_drop");
        send(32'h00000001);
        exp_q.push_back(32'h12345678);
        send(32'h12345678);
        drain();

        // Method 0 with length 2 and method 1 at MAX_LEN are both dropped.
        send(32'h00000002);
        note_err();
        send(32'hAAAA0001);
        send(32'hAAAA0002);
        send(32'h00010008);
        note_err();
        for (int i = 0; i < 8; i++) send(32'hBBBB0000 + i);
        chk_err("err_after_len");
        send(32'h00000001);
        exp_q.push_back(32'h00C0FFEE);
        send(32'h00C0FFEE);
        drain();

        // Back-pressure: third payload stalls until downstream drains.
        @(posedge CLK);
        #1 rdy_say = 1'b0;
        send(32'h00000001);
        exp_q.push_back(32'hA0000001);
        send(32'hA0000001);
        send(32'h00000001);
        exp_q.push_back(32'hB0000002);
        send(32'hB0000002);
        send(32'h00000001);
        exp_q.push_back(32'hC0000003);
        @(negedge CLK);
        enq_v  = 32'hC0000003;
        en_enq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_rdy", {31'd0, rdy_enq}, 32'd0);
            check("stall_no_say", {31'd0, en_say}, 32'd0);
            @(negedge CLK);
        end
        @(posedge CLK);
        #1 rdy_say = 1'b1;
        check("no_bypass_rdy", {31'd0, rdy_enq}, 32'd0);
        begin
            int t;
            t = 0;
            @(negedge CLK);
            while (!rdy_enq && t < 50) begin
                @(negedge CLK);
                t++;
            end
            check("stall_release", {31'd0, rdy_enq}, 32'd1);
        end
        @(posedge CLK);
        #1 en_enq = 1'b0;
        drain();

        // Reset mid-message: next word is a header again.
        send(32'h00000001);
        do_reset();
        send(32'hCAFEF00D);
        note_err();
        repeat (5) @(negedge CLK);
        check("cafe_no_say", {31'd0, en_say}, 32'd0);
        chk_err("err_cafe");
        do_reset();

        // Size queries and the zero-length say header.
        ms_method = 16'd0;
        #1 check("msize_0", {16'd0, ms_size}, 32'd32);
        ms_method = 16'd7;
        #1 check("msize_7", {16'd0, ms_size}, 32'd0);
        ms_method = 16'hFFFF;
        #1 check("msize_ffff", {16'd0, ms_size}, 32'd0);
        send(32'h00000000);
        note_err();
        check("zero_len_rdy", {31'd0, rdy_enq}, 32'd1);
        chk_err("err_zero_len");
        send(32'h00000001);
        exp_q.push_back(32'h0BADF00D);
        send(32'h0BADF00D);
        drain();

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
